// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and default sizes.
// Optional subtract mode is enabled by defining SERIAL_SUB_EN.
package serial_add_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 5;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder; building block of the serial full-adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_fa_cell.sv
// One-bit full adder made from two half adders and an OR of their carries.
module serial_fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a (x),
        .b (y),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (ci),
        .s (s),
        .c (c1)
    );

    assign co = c0 | c1;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder cell, LSB first, start/busy/done handshake.
// Defining SERIAL_SUB_EN adds a 'sub' input selecting a - b instead of a + b.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sha_q, sha_d;
    logic [WIDTH-1:0]   shb_q, shb_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;

    logic               cell_s;
    logic               cell_co;
    logic [WIDTH:0]     acc_ext;
    logic [WIDTH-1:0]   acc_shift;
    logic [WIDTH-1:0]   b_load;
    logic               carry_init;

    serial_fa_cell u_cell (
        .x  (sha_q[0]),
        .y  (shb_q[0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

`ifdef SERIAL_SUB_EN
    // Two's-complement subtract: invert b and feed a carry-in of 1.
    assign b_load     = sub ? ~b : b;
    assign carry_init = sub;
`else
    assign b_load     = b;
    assign carry_init = 1'b0;
`endif

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        sha_d     = sha_q;
        shb_d     = shb_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        done_d    = 1'b0;
        // Widened shift keeps the expression legal when WIDTH is 1.
        acc_ext   = {cell_s, acc_q} >> 1;
        acc_shift = acc_ext[WIDTH-1:0];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sha_d   = a;
                    shb_d   = b_load;
                    carry_d = carry_init;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d   = acc_shift;
                sha_d   = sha_q >> 1;
                shb_d   = shb_q >> 1;
                carry_d = cell_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = acc_shift;
                    cout_d  = cell_co;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       sub1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8), .CNT_W(5)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_add_ctrl #(.WIDTH(1), .CNT_W(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
`ifdef SERIAL_SUB_EN
        .sub   (sub1),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts edges after the accepting edge until done is seen; -1 if the budget runs out.
    task automatic wait_done(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_add(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic tsub, input logic [7:0] esum, input logic ecout);
        int n;
        @(negedge clk);
        a = ta; b = tb_v; sub = tsub; start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " busy_on_accept"}, busy, 1);
        @(negedge clk);
        start = 1'b0;
        wait_done(20, n);
        check({tag, " latency"}, n, 8);
        check({tag, " sum"}, sum, esum);
        check({tag, " cout"}, cout, ecout);
        check({tag, " busy_in_done"}, busy, 0);
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, done, 0);
    endtask

    initial begin
        int  n;
        int  seen;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0;
        #23;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_add("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_add("add_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);

        // start pulsed mid-run must be ignored
        @(negedge clk);
        a = 8'h01; b = 8'h02; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("sum held during run", sum, 8'hFE);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            start = (i == 3);
            if (i == 3) a = 8'h40;
            if (done) begin n = i; break; end
        end
        start = 1'b0;
        check("ignore latency", n, 8);
        check("ignore sum", sum, 8'h03);
        @(posedge clk);
        #1;
        check("ignore no requeue", busy, 0);

        // start held high; operand change mid-run ignored; back-to-back add
        @(negedge clk);
        a = 8'd3; b = 8'd4; start = 1'b1;
        @(posedge clk);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) a = 8'd9;
            if (done) begin n = i; break; end
        end
        check("held latency1", n, 8);
        check("held sum1", sum, 8'd7);
        @(posedge clk);
        #1;
        check("held b2b busy", busy, 1);
        check("held b2b done low", done, 0);
        @(negedge clk);
        start = 1'b0;
        wait_done(20, n);
        check("held latency2", n, 8);
        check("held sum2", sum, 8'd13);
        check("held cout2", cout, 0);

        // reset in the middle of an add
        @(negedge clk);
        a = 8'h10; b = 8'h20; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort sum", sum, 0);
        check("abort cout", cout, 0);
        check("abort done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        check("abort no done", seen, 0);
        run_add("after_abort", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

`ifdef SERIAL_SUB_EN
        run_add("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
        run_add("sub_07_05", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
`endif

        // WIDTH=1 instance
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
        @(posedge clk);
        #1;
        check("w1 busy", busy1, 1);
        check("w1 done early", done1, 0);
        @(negedge clk);
        start1 = 1'b0;
        @(posedge clk);
        #1;
        check("w1 done", done1, 1);
        check("w1 busy off", busy1, 0);
        check("w1 sum", sum1, 0);
        check("w1 cout", cout1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
